// File: rtl/npcnn_mc_conv_if.sv
`default_nettype none
// ============================================================================
// Module   : npcnn_mc_conv_if
// Brief    : Load, start and result-stream bundle of the multi-channel conv engine
// Revision : 1.0
// ============================================================================
interface npcnn_mc_conv_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
);
  logic                    a_wr;
  logic [DW-1:0]           a_data;
  logic                    f_wr;
  logic [DW:0]             f_data;
  logic                    go;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out;
  logic [7:0]              out_row;
  logic [7:0]              out_col;
  logic                    busy;
  logic                    done;

  modport master (
    output a_wr, a_data, f_wr, f_data, go, out_ready,
    input  out_valid, out, out_row, out_col, busy, done
  );

  modport slave (
    input  a_wr, a_data, f_wr, f_data, go, out_ready,
    output out_valid, out, out_row, out_col, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/npcnn_mc_conv.sv
`default_nettype none
// ============================================================================
// Module   : npcnn_mc_conv
// Brief    : Multi-channel strided/padded 2-D convolution, one MAC per cycle
// Revision : 1.0
// ============================================================================
module npcnn_mc_conv #(
  parameter int DW     = 8,
  parameter int A_SIZE = 6,
  parameter int F_SIZE = 3,
  parameter int CH     = 2,
  parameter int STRIDE = 1,
  parameter int PAD    = 0,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  npcnn_mc_conv_if.slave    bus
);
  localparam int O_SIZE = (A_SIZE + 2*PAD - F_SIZE) / STRIDE + 1;
  localparam int A_N    = CH * A_SIZE * A_SIZE;
  localparam int F_N    = CH * F_SIZE * F_SIZE;
  localparam int A_AW   = (A_N > 1) ? $clog2(A_N) : 1;
  localparam int F_AW   = (F_N > 1) ? $clog2(F_N) : 1;
  localparam int PROD_W = 2*DW + 2;
  localparam int SUM_W0 = PROD_W + $clog2(F_N + 1);
  // At least one bit wider than the output so the clamp bounds are representable
  localparam int SUM_W  = (SUM_W0 > ACC_W) ? SUM_W0 : ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [DW-1:0]           img_q [A_N];
  logic signed [DW:0]      flt_q [F_N];

  logic [1:0]              state_q, state_d;
  logic [A_AW-1:0]         a_ptr_q, a_ptr_d;
  logic [F_AW-1:0]         f_ptr_q, f_ptr_d;
  logic [7:0]              ch_q, ch_d, fr_q, fr_d, fc_q, fc_d;
  logic [7:0]              r_q, r_d, c_q, c_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic [7:0]              row_q, row_d, col_q, col_d;
  logic                    valid_q, valid_d, done_q, done_d;

  int                      w_y, w_x, w_aidx_i;
  logic                    w_inb, w_last, w_final;
  logic [A_AW-1:0]         w_aidx;
  logic [F_AW-1:0]         w_fidx;
  logic [DW-1:0]           w_pix;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_sat;

  // Padding taps fall outside the stored image and read as zero
  always_comb begin
    w_y      = int'(r_q) * STRIDE + int'(fr_q) - PAD;
    w_x      = int'(c_q) * STRIDE + int'(fc_q) - PAD;
    w_inb    = (w_y >= 0) && (w_y < A_SIZE) && (w_x >= 0) && (w_x < A_SIZE);
    w_aidx_i = int'(ch_q) * A_SIZE * A_SIZE + w_y * A_SIZE + w_x;
    w_aidx   = w_inb ? A_AW'(w_aidx_i) : '0;
    w_fidx   = F_AW'(int'(ch_q) * F_SIZE * F_SIZE + int'(fr_q) * F_SIZE + int'(fc_q));
    w_pix    = w_inb ? img_q[w_aidx] : '0;
    w_prod   = PROD_W'($signed({1'b0, w_pix})) * PROD_W'(flt_q[w_fidx]);
    w_sum    = acc_q + SUM_W'(w_prod);
    if (w_sum > SAT_MAX)      w_sat = SAT_MAX[ACC_W-1:0];
    else if (w_sum < SAT_MIN) w_sat = SAT_MIN[ACC_W-1:0];
    else                      w_sat = w_sum[ACC_W-1:0];
    w_last  = (ch_q == 8'(CH-1)) && (fr_q == 8'(F_SIZE-1)) && (fc_q == 8'(F_SIZE-1));
    w_final = (r_q == 8'(O_SIZE-1)) && (c_q == 8'(O_SIZE-1));
  end

  always_comb begin
    state_d = state_q;
    a_ptr_d = a_ptr_q;
    f_ptr_d = f_ptr_q;
    ch_d    = ch_q;
    fr_d    = fr_q;
    fc_d    = fc_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    out_d   = out_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.a_wr) a_ptr_d = (a_ptr_q == A_AW'(A_N-1)) ? '0 : a_ptr_q + 1'b1;
        if (bus.f_wr) f_ptr_d = (f_ptr_q == F_AW'(F_N-1)) ? '0 : f_ptr_q + 1'b1;
        if (bus.go) begin
          state_d = S_MAC;
          a_ptr_d = '0;
          f_ptr_d = '0;
          r_d     = '0;
          c_d     = '0;
          ch_d    = '0;
          fr_d    = '0;
          fc_d    = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = w_sum;
        if (fc_q == 8'(F_SIZE-1)) begin
          fc_d = '0;
          if (fr_q == 8'(F_SIZE-1)) begin
            fr_d = '0;
            ch_d = ch_q + 8'd1;
          end else begin
            fr_d = fr_q + 8'd1;
          end
        end else begin
          fc_d = fc_q + 8'd1;
        end
        if (w_last) begin
          ch_d    = '0;
          out_d   = w_sat;
          row_d   = r_q;
          col_d   = c_q;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          if (w_final) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_MAC;
            if (c_q == 8'(O_SIZE-1)) begin
              c_d = '0;
              r_d = r_q + 8'd1;
            end else begin
              c_d = c_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_ptr_q <= '0;
      f_ptr_q <= '0;
      ch_q    <= '0;
      fr_q    <= '0;
      fc_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_ptr_q <= a_ptr_d;
      f_ptr_q <= f_ptr_d;
      ch_q    <= ch_d;
      fr_q    <= fr_d;
      fc_q    <= fc_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Storage arrays survive reset; only the write pointers are cleared
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.a_wr) img_q[a_ptr_q] <= bus.a_data;
    if (state_q == S_IDLE && bus.f_wr) flt_q[f_ptr_q] <= $signed(bus.f_data);
  end

  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_npcnn_mc_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_npcnn_mc_conv
// Brief    : Directed scoreboard bench over four parameter sets of the engine
// Revision : 1.0
// ============================================================================
module tb_npcnn_mc_conv;
  localparam int N_DUT = 4;
  localparam int P_CH  [N_DUT] = '{1, 1, 2, 2};
  localparam int P_ST  [N_DUT] = '{1, 1, 2, 1};
  localparam int P_PAD [N_DUT] = '{0, 1, 0, 0};

  typedef struct {
    int     r;
    int     c;
    longint v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;
  logic a_wr = 1'b0, f_wr = 1'b0, go = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0;
  logic [8:0] f_data = '0;

  logic              v_valid [N_DUT];
  logic signed [19:0] v_out  [N_DUT];
  logic [7:0]        v_row   [N_DUT];
  logic [7:0]        v_col   [N_DUT];
  logic              v_busy  [N_DUT];
  logic              v_done  [N_DUT];

  int     tests = 0;
  int     fails = 0;
  int     img_m [0:1][0:5][0:5];
  int     flt_m [0:1][0:2][0:2];
  exp_t   sb [$];
  longint got [0:63];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    npcnn_mc_conv_if bus ();
    assign bus.a_wr      = a_wr && (sel == g);
    assign bus.f_wr      = f_wr && (sel == g);
    assign bus.go        = go && (sel == g);
    assign bus.out_ready = out_ready && (sel == g);
    assign bus.a_data    = a_data;
    assign bus.f_data    = f_data;
    assign v_valid[g]    = bus.out_valid;
    assign v_out[g]      = bus.out;
    assign v_row[g]      = bus.out_row;
    assign v_col[g]      = bus.out_col;
    assign v_busy[g]     = bus.busy;
    assign v_done[g]     = bus.done;
    npcnn_mc_conv #(
      .DW(8), .A_SIZE(6), .F_SIZE(3), .CH(P_CH[g]),
      .STRIDE(P_ST[g]), .PAD(P_PAD[g]), .ACC_W(20)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(int ch_n, int s, int p, int r, int c);
    longint acc = 0;
    for (int ch = 0; ch < ch_n; ch++)
      for (int fr = 0; fr < 3; fr++)
        for (int fc = 0; fc < 3; fc++) begin
          int y = r*s + fr - p;
          int x = c*s + fc - p;
          if (y >= 0 && y < 6 && x >= 0 && x < 6)
            acc += longint'(img_m[ch][y][x]) * longint'(flt_m[ch][fr][fc]);
        end
    if (acc > 524287) acc = 524287;
    if (acc < -524288) acc = -524288;
    return acc;
  endfunction

  task automatic load(input int ch_n);
    for (int ch = 0; ch < ch_n; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          a_wr = 1'b1; a_data = 8'(img_m[ch][r][c]);
          @(negedge clk);
        end
    a_wr = 1'b0;
    for (int ch = 0; ch < ch_n; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          f_wr = 1'b1; f_data = 9'(flt_m[ch][r][c]);
          @(negedge clk);
        end
    f_wr = 1'b0;
  endtask

  task automatic run_conv(input int ch_n, input int s, input int p, input bit stall, input bit inject);
    int   o = (6 + 2*p - 3) / s + 1;
    int   cnt = 0;
    int   dn = 0;
    bit   first = 1'b1;
    exp_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) got[i] = -1;
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) sb.push_back('{r, c, model(ch_n, s, p, r, c)});
    out_ready = !stall;
    go = 1'b1;
    while (sb.size() > 0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) go = 1'b0;
      if (inject && cnt == 3) begin go = 1'b1; a_wr = 1'b1; a_data = 8'd200; end
      if (inject && cnt == 4) begin go = 1'b0; a_wr = 1'b0; end
      if (v_valid[sel]) begin
        e = sb[0];
        if (first) begin
          first = 1'b0;
          check("first_latency", cnt, ch_n*9 + 1);
          if (stall) begin
            for (int k = 0; k < 5; k++) begin
              @(negedge clk);
              cnt++;
              check("stall_valid", v_valid[sel], 1);
              check("stall_out", v_out[sel], e.v);
              check("stall_row", v_row[sel], e.r);
              check("stall_col", v_col[sel], e.c);
            end
            out_ready = 1'b1;
          end
        end
        e = sb.pop_front();
        check($sformatf("out(%0d,%0d)", e.r, e.c), v_out[sel], e.v);
        check("out_row", v_row[sel], e.r);
        check("out_col", v_col[sel], e.c);
        got[e.r*8 + e.c] = longint'(v_out[sel]);
      end
    end
    check("outputs_pending", sb.size(), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (v_done[sel]) dn++;
    end
    check("done_pulses", dn, 1);
    check("busy_after_done", v_busy[sel], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      check("rst_valid", v_valid[d], 0);
      check("rst_busy", v_busy[d], 0);
    end
    check("rst_out", v_out[0], 0);
    check("rst_done", v_done[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // All-ones 3x3 on 6x6, stalled first output, go/a_wr injected mid-MAC
    foreach (img_m[ch, r, c]) img_m[ch][r][c] = 1;
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = 1;
    sel = 0;
    load(1);
    run_conv(1, 1, 0, 1'b1, 1'b1);

    // Same data with one ring of zero padding
    sel = 1;
    load(1);
    run_conv(1, 1, 1, 1'b0, 1'b0);
    check("pad_corner", got[0], 4);
    check("pad_edge", got[2], 6);
    check("pad_interior", got[2*8 + 2], 9);

    // Stride 2, two channels, ramp image in channel 0 only
    foreach (img_m[ch, r, c]) img_m[ch][r][c] = (ch == 0) ? r*6 + c : 0;
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = (ch == 0) ? 1 : 3;
    sel = 2;
    load(2);
    run_conv(2, 2, 0, 1'b0, 1'b0);
    check("stride_00", got[0], 63);
    check("stride_01", got[1], 81);
    check("stride_10", got[8], 171);
    check("stride_11", got[9], 189);

    // Positive and negative saturation
    foreach (img_m[ch, r, c]) img_m[ch][r][c] = 255;
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = 255;
    sel = 3;
    load(2);
    run_conv(2, 1, 0, 1'b0, 1'b0);
    check("sat_pos", got[0], 524287);
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = -256;
    load(2);
    run_conv(2, 1, 0, 1'b0, 1'b0);
    check("sat_neg", got[3*8 + 3], -524288);

    // Abort during the second pixel's MAC, then a fresh random run
    foreach (img_m[ch, r, c]) img_m[ch][r][c] = 1;
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = 1;
    sel = 0;
    load(1);
    out_ready = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_abort_out", v_out[0], 9);
    rst = 1'b1;
    #1;
    check("abort_valid", v_valid[0], 0);
    check("abort_out", v_out[0], 0);
    check("abort_row", v_row[0], 0);
    check("abort_col", v_col[0], 0);
    check("abort_busy", v_busy[0], 0);
    check("abort_done", v_done[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_valid", v_valid[0], 0);
    check("idle_done", v_done[0], 0);
    check("idle_busy", v_busy[0], 0);
    foreach (img_m[ch, r, c]) img_m[ch][r][c] = int'($urandom_range(0, 255));
    foreach (flt_m[ch, r, c]) flt_m[ch][r][c] = int'($urandom_range(0, 511)) - 256;
    load(1);
    run_conv(1, 1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
